// File: rtl/pixel_loader.sv
// ---------------------------------------------------------------------------
// pixel_loader
//
// Upstream feeder for the network's image memory. Accepts one frame of
// unsigned pixels on a valid/ready stream, converts each pixel to signed
// 32-bit fixed point, and writes the frame to addresses 0..NUM_PIXELS-1.
// Once the last write has committed, it raises image_ready. image_ready
// stays high until the consumer pulses image_release.
//
// Ports
//   clk               clock
//   reset             synchronous, active-high reset
//   start             arm loading of one frame (honoured only in IDLE)
//   pix_valid         a pixel beat is offered
//   pix_data          unsigned pixel value
//   pix_last          marks the final pixel of the frame
//   pix_ready         loader accepts a beat this cycle (state == LOAD)
//   mem_write_addr    memory write address (registered)
//   mem_data_in       converted pixel, signed 32-bit (registered)
//   mem_write_enable  one-cycle write strobe per accepted beat (registered)
//   image_ready       memory holds a complete frame
//   image_release     consumer has finished with the frame
//   frame_error       sticky framing error for the current frame
//   pixel_count       pixels accepted in the current frame
// ---------------------------------------------------------------------------
module pixel_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 16,
    parameter int PIX_W      = 8,
    parameter int FRAC_BITS  = 16,
    parameter int CENTER     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_data,
    input  logic                     pix_last,
    output logic                     pix_ready,
    output logic [ADDR_W-1:0]        mem_write_addr,
    output logic signed [31:0]       mem_data_in,
    output logic                     mem_write_enable,
    output logic                     image_ready,
    input  logic                     image_release,
    output logic                     frame_error,
    output logic [ADDR_W-1:0]        pixel_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        FULL  = 2'd3
    } state_t;

    localparam int                SHIFT    = FRAC_BITS - PIX_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
    // Centering offset 2^(PIX_W-1), held one bit wider so the subtraction
    // below stays signed with room for the full -2^(PIX_W-1)..2^(PIX_W-1)-1 range.
    localparam logic [PIX_W:0]    OFFSET   =
        (CENTER != 0) ? (PIX_W + 1)'(1 << (PIX_W - 1)) : '0;

    state_t                   r_state;
    logic                     r_we;
    logic [ADDR_W-1:0]        r_addr;
    logic signed [31:0]       r_data;
    logic                     r_image_ready;
    logic                     r_err;
    logic [ADDR_W-1:0]        r_count;

    logic                     w_accept;
    logic signed [PIX_W:0]    w_p;
    logic signed [31:0]       w_ext;
    logic signed [31:0]       w_conv;

    // ------------------------------------------------------------------
    // Pixel conversion: zero-extend, optionally centre, sign-extend, scale.
    // ------------------------------------------------------------------
    assign w_p      = $signed({1'b0, pix_data}) - $signed(OFFSET);
    assign w_ext    = {{(32 - PIX_W - 1){w_p[PIX_W]}}, w_p};
    assign w_conv   = w_ext <<< SHIFT;

    assign pix_ready = (r_state == LOAD);
    assign w_accept  = pix_valid && pix_ready;

    // ------------------------------------------------------------------
    // Control FSM with registered write port and status outputs.
    // ------------------------------------------------------------------
    // NOTE: every register here is state, so all assignments are
    // non-blocking; the default r_we <= 0 at the top is overridden only on
    // an accepted beat, which yields exactly one strobe cycle per beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_image_ready <= 1'b0;
            r_err         <= 1'b0;
            r_count       <= '0;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_state <= LOAD;
                    end
                end

                LOAD: begin
                    if (w_accept) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_count;
                        r_data  <= w_conv;
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_IDX) begin
                            // Frame completes on the count even when the
                            // source forgot to mark its last beat.
                            if (!pix_last) begin
                                r_err <= 1'b1;
                            end
                            r_state <= FLUSH;
                        end else if (pix_last) begin
                            // Short frame: keep the beat, flag it, and never
                            // announce an image.
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end

                // The final write is on the memory port during this cycle.
                FLUSH: begin
                    r_image_ready <= 1'b1;
                    r_state       <= FULL;
                end

                FULL: begin
                    if (image_release) begin
                        r_image_ready <= 1'b0;
                        r_state       <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_write_enable = r_we;
    assign mem_write_addr   = r_addr;
    assign mem_data_in      = r_data;
    assign image_ready      = r_image_ready;
    assign frame_error      = r_err;
    assign pixel_count      = r_count;

endmodule

// File: tb/tb_pixel_loader.sv
// ---------------------------------------------------------------------------
// tb_pixel_loader
//
// Directed bench for pixel_loader. Accepted beats push their expected
// {address, data} into a scoreboard queue; a monitor on the falling edge
// pops and compares every write strobe. A second instance with CENTER=1 and
// a 3-pixel frame covers the centred conversion.
// ---------------------------------------------------------------------------
module tb_pixel_loader;

    localparam int N = 784;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_last;
    logic        pix_ready;
    logic [15:0] mem_write_addr;
    logic [31:0] mem_data_in;
    logic        mem_write_enable;
    logic        image_ready;
    logic        image_release;
    logic        frame_error;
    logic [15:0] pixel_count;

    logic        c_start;
    logic        c_pix_valid;
    logic [7:0]  c_pix_data;
    logic        c_pix_last;
    logic        c_pix_ready;
    logic [15:0] c_mem_write_addr;
    logic [31:0] c_mem_data_in;
    logic        c_mem_write_enable;
    logic        c_image_ready;
    logic        c_frame_error;
    logic [15:0] c_pixel_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         sb[$];
    int          exp_addr;
    bit          seen_ready;

    always #5 clk = ~clk;

    pixel_loader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .pix_valid        (pix_valid),
        .pix_data         (pix_data),
        .pix_last         (pix_last),
        .pix_ready        (pix_ready),
        .mem_write_addr   (mem_write_addr),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .image_ready      (image_ready),
        .image_release    (image_release),
        .frame_error      (frame_error),
        .pixel_count      (pixel_count)
    );

    pixel_loader #(.NUM_PIXELS(3), .CENTER(1)) dut_c (
        .clk              (clk),
        .reset            (reset),
        .start            (c_start),
        .pix_valid        (c_pix_valid),
        .pix_data         (c_pix_data),
        .pix_last         (c_pix_last),
        .pix_ready        (c_pix_ready),
        .mem_write_addr   (c_mem_write_addr),
        .mem_data_in      (c_mem_data_in),
        .mem_write_enable (c_mem_write_enable),
        .image_ready      (c_image_ready),
        .image_release    (1'b0),
        .frame_error      (c_frame_error),
        .pixel_count      (c_pixel_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Q8 pixel in a Q16 word: the pixel byte lands in bits 15:8.
    function automatic logic [31:0] conv0(input logic [7:0] d);
        return {16'h0000, d, 8'h00};
    endfunction

    // Scoreboard monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (image_ready === 1'b1) seen_ready = 1'b1;
        if (mem_write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write_addr", 32'(mem_write_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("write_addr", 32'(mem_write_addr), 32'(e.addr));
                check("write_data", mem_data_in, e.data);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int waited;
        waited    = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        while (pix_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (pix_ready !== 1'b1) begin
            check("beat_ready_timeout", 32'(pix_ready), 32'd1);
        end else begin
            sb.push_back('{addr: 16'(exp_addr), data: conv0(d)});
            exp_addr++;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    // Start a frame and offer n beats; beat last_idx carries pix_last.
    task automatic run_frame(input int n, input int last_idx, input bit gaps);
        do_start();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = 0;
                while ($urandom_range(0, 1) == 1 && g < 8) begin
                    @(posedge clk); #1;
                    g++;
                end
            end
            send_beat(8'(i % 256), i == last_idx);
        end
    endtask

    // After the final accept: FLUSH one cycle, then FULL with image_ready.
    task automatic check_full(input string tag, input logic err);
        @(negedge clk);
        check({tag, "_flush_image_ready"}, 32'(image_ready), 32'd0);
        check({tag, "_flush_pix_ready"}, 32'(pix_ready), 32'd0);
        @(negedge clk);
        check({tag, "_image_ready"}, 32'(image_ready), 32'd1);
        check({tag, "_frame_error"}, 32'(frame_error), 32'(err));
        check({tag, "_pixel_count"}, 32'(pixel_count), 32'(N));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic release_frame();
        image_release = 1'b1;
        @(posedge clk); #1;
        image_release = 1'b0;
        @(negedge clk);
        check("release_image_ready", 32'(image_ready), 32'd0);
    endtask

    initial begin
        logic [7:0]  c_pix [3];
        logic [31:0] c_exp [3];
        c_pix = '{8'd0, 8'd128, 8'd255};
        c_exp = '{32'hFFFF_8000, 32'h0000_0000, 32'h0000_7F00};

        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        pix_last = 1'b0; image_release = 1'b0;
        c_start = 1'b0; c_pix_valid = 1'b0; c_pix_data = '0; c_pix_last = 1'b0;
        seen_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_we", 32'(mem_write_enable), 32'd0);
        check("rst_addr", 32'(mem_write_addr), 32'd0);
        check("rst_data", mem_data_in, 32'd0);
        check("rst_image_ready", 32'(image_ready), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_pixel_count", 32'(pixel_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Beats offered in IDLE are not consumed.
        pix_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pix_valid = 1'b0;
        @(negedge clk);
        check("idle_no_consume_count", 32'(pixel_count), 32'd0);

        // Full frame, back to back.
        run_frame(N, N - 1, 1'b0);
        check_full("full", 1'b0);
        release_frame();

        // Same frame with random gaps on pix_valid.
        run_frame(N, N - 1, 1'b1);
        check_full("gaps", 1'b0);
        release_frame();

        // Short frame: pix_last on beat 99.
        seen_ready = 1'b0;
        run_frame(100, 99, 1'b0);
        @(negedge clk);
        check("short_pix_ready", 32'(pix_ready), 32'd0);
        check("short_frame_error", 32'(frame_error), 32'd1);
        check("short_pixel_count", 32'(pixel_count), 32'd100);
        repeat (5) @(negedge clk);
        check("short_sb_empty", 32'(sb.size()), 32'd0);
        check("short_never_ready", 32'(seen_ready), 32'd0);

        // Missing pix_last on beat 783: error, but the frame completes.
        run_frame(N, -1, 1'b0);
        check_full("nolast", 1'b1);

        // start while FULL is ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("full_start_pix_ready", 32'(pix_ready), 32'd0);
        check("full_start_image_ready", 32'(image_ready), 32'd1);
        check("full_start_pixel_count", 32'(pixel_count), 32'(N));

        // release together with start: back to IDLE, start dropped.
        image_release = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        image_release = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rel_start_image_ready", 32'(image_ready), 32'd0);
        check("rel_start_pix_ready", 32'(pix_ready), 32'd0);
        @(negedge clk);
        check("rel_start_still_idle", 32'(pix_ready), 32'd0);
        check("rel_start_error_held", 32'(frame_error), 32'd1);

        // New frame from IDLE, reset after 400 accepts.
        run_frame(400, -1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_pre_count", 32'(pixel_count), 32'd400);
        check("midrst_pre_error", 32'(frame_error), 32'd0);
        @(negedge clk);
        check("midrst_pix_ready", 32'(pix_ready), 32'd0);
        check("midrst_we", 32'(mem_write_enable), 32'd0);
        check("midrst_addr", 32'(mem_write_addr), 32'd0);
        check("midrst_data", mem_data_in, 32'd0);
        check("midrst_image_ready", 32'(image_ready), 32'd0);
        check("midrst_frame_error", 32'(frame_error), 32'd0);
        check("midrst_pixel_count", 32'(pixel_count), 32'd0);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Restart after reset begins again at address 0.
        run_frame(N, N - 1, 1'b0);
        check_full("restart", 1'b0);
        release_frame();

        // Centred conversion on the 3-pixel instance.
        c_start = 1'b1;
        @(posedge clk); #1;
        c_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            c_pix_valid = 1'b1;
            c_pix_data  = c_pix[k];
            c_pix_last  = (k == 2);
            check("c_pix_ready", 32'(c_pix_ready), 32'd1);
            @(posedge clk); #1;
            c_pix_valid = 1'b0;
            c_pix_last  = 1'b0;
            @(negedge clk);
            check("c_we", 32'(c_mem_write_enable), 32'd1);
            check("c_addr", 32'(c_mem_write_addr), 32'(k));
            check("c_data", c_mem_data_in, c_exp[k]);
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        check("c_image_ready", 32'(c_image_ready), 32'd1);
        check("c_frame_error", 32'(c_frame_error), 32'd0);
        check("c_pixel_count", 32'(c_pixel_count), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
